// File: rtl/booth_mult_sched.sv
// Sequential radix-2 Booth multiplier shared by NREQ requesters via round-robin.
// Optional macro BOOTH_EARLY_DONE_EN: finish early once the remaining Booth steps are no-ops.
module booth_mult_sched #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]      rsp_product,
    output logic                    busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       grant;
    logic [IDW-1:0]       grant_nx;
    logic                 found;
    logic [IDW:0]         idx;
    logic [WIDTH-1:0]     m;
    logic [WIDTH-1:0]     q;
    logic                 q_1;
    logic [WIDTH:0]       hi;
    logic [WIDTH:0]       mext;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       hi_nx;
    logic [WIDTH-1:0]     q_nx;
    logic [CW-1:0]        cnt;
    logic                 last;
    logic [2*WIDTH-1:0]   prod_nx;

    // Round-robin search: first valid requester at or after rr_ptr, with wrap
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) begin
                idx = idx - (IDW+1)'(NREQ);
            end
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                grant = idx[IDW-1:0];
            end
        end
        grant_nx = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
    end

    // Accept strobe only while idle and out of reset
    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && found) begin
            req_ready[grant] = 1'b1;
        end
    end

    // One Booth add/subtract followed by the arithmetic shift of {HI,Q,q_1}
    always_comb begin
        mext = {m[WIDTH-1], m};
        unique case ({q[0], q_1})
            2'b10:   sum = hi - mext;
            2'b01:   sum = hi + mext;
            default: sum = hi;
        endcase
        hi_nx = {sum[WIDTH], sum[WIDTH:1]};
        q_nx  = {sum[0], q[WIDTH-1:1]};
    end

`ifdef BOOTH_EARLY_DONE_EN
    logic [CW-1:0]            rem;
    logic signed [2*WIDTH:0]  wide;

    // Stop once the unexamined multiplier bits can only produce no-op steps
    always_comb begin
        rem  = CW'(WIDTH - 1) - cnt;
        last = 1'b1;
        for (int j = 0; j < WIDTH; j++) begin
            if (CW'(j) <= rem && q[j] != q[0]) begin
                last = 1'b0;
            end
        end
        wide    = $signed({hi_nx, q_nx}) >>> rem;
        prod_nx = (2*WIDTH)'(wide);
    end
`else
    // Fixed WIDTH iterations
    always_comb begin
        last    = (cnt == CW'(WIDTH - 1));
        prod_nx = {hi_nx[WIDTH-1:0], q_nx};
    end
`endif

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
            busy        <= 1'b0;
            m           <= '0;
            q           <= '0;
            q_1         <= 1'b0;
            hi          <= '0;
            cnt         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        m      <= req_b[int'(grant)*WIDTH +: WIDTH];
                        q      <= req_a[int'(grant)*WIDTH +: WIDTH];
                        hi     <= '0;
                        q_1    <= 1'b0;
                        cnt    <= '0;
                        rsp_id <= grant;
                        rr_ptr <= grant_nx;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    hi  <= hi_nx;
                    q   <= q_nx;
                    q_1 <= q[0];
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        rsp_product <= prod_nx;
                        rsp_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
